// File: rtl/line_cache.sv
// line_cache: direct-mapped, write-back, write-allocate data cache.
// Word hits complete in the request cycle. Misses write back a dirty victim
// line, fetch the missing line and hold `miss` until the access can hit.
module line_cache #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  parameter int TAG_ADDR_LEN  = 30 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               rd_req,
  input  logic                               wr_req,
  input  logic [31:0]                        addr,
  input  logic [31:0]                        wr_data,
  output logic [31:0]                        rd_data,
  output logic                               miss,
  output logic                               mem_read_request,
  output logic                               mem_write_request,
  output logic [31:0]                        mem_addr,
  output logic [32*(1<<LINE_ADDR_LEN)-1:0]   mem_write_data,
  input  logic                               mem_request_finish,
  input  logic [32*(1<<LINE_ADDR_LEN)-1:0]   mem_read_data
);

  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int SET_SIZE  = 1 << SET_ADDR_LEN;

  typedef enum logic [1:0] {READY, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;

  state_t state, state_next;

  // Per-line bookkeeping and storage.
  logic [SET_SIZE-1:0]     valid;
  logic [SET_SIZE-1:0]     dirty;
  logic [TAG_ADDR_LEN-1:0] tag_mem  [SET_SIZE];
  logic [31:0]             data_mem [SET_SIZE][LINE_SIZE];

  // Address split: byte | word offset | set index | tag.
  logic [LINE_ADDR_LEN-1:0] word_off;
  logic [SET_ADDR_LEN-1:0]  set_idx;
  logic [TAG_ADDR_LEN-1:0]  addr_tag;
  logic                     unused_byte_bits;

  assign word_off         = addr[LINE_ADDR_LEN+1:2];
  assign set_idx          = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
  assign addr_tag         = addr[31:32-TAG_ADDR_LEN];
  assign unused_byte_bits = ^addr[1:0];

  logic                          access;
  logic                          hit;
  logic                          victim_dirty;
  logic [32*LINE_SIZE-1:0]       victim_line;

  assign access       = rd_req | wr_req;
  assign victim_dirty = valid[set_idx] & dirty[set_idx];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    if (!rst_n) state <= READY;
    else        state <= state_next;
  end

  // Next-state logic: a miss in READY starts a swap; finish pulses advance it.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      READY:      if (access && !hit) state_next = victim_dirty ? SWAP_OUT : SWAP_IN;
      SWAP_OUT:   if (mem_request_finish) state_next = SWAP_IN;
      SWAP_IN:    if (mem_request_finish) state_next = SWAP_IN_OK;
      SWAP_IN_OK: state_next = READY;
      default:    state_next = READY;
    endcase
  end

  // CPU-side outputs: hit detection, stall and combinational read word.
  always_comb begin
    hit     = valid[set_idx] && (tag_mem[set_idx] == addr_tag) && (state == READY);
    miss    = access && !hit;
    rd_data = data_mem[set_idx][word_off];
  end

  // Pack the indexed line for write-back; word 0 lands in the MSB slice.
  always_comb begin
    victim_line = '0;
    for (int k = 0; k < LINE_SIZE; k++)
      victim_line[32*(LINE_SIZE-k)-1 -: 32] = data_mem[set_idx][k];
  end

  // Memory request registers and valid/dirty bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid             <= '0;
      dirty             <= '0;
      mem_read_request  <= 1'b0;
      mem_write_request <= 1'b0;
      mem_addr          <= '0;
      mem_write_data    <= '0;
    end else begin
      case (state)
        READY: begin
          if (hit && wr_req) begin
            dirty[set_idx] <= 1'b1;
          end else if (access && !hit) begin
            if (victim_dirty) begin
              mem_write_request <= 1'b1;
              mem_addr          <= {tag_mem[set_idx], set_idx, {(LINE_ADDR_LEN+2){1'b0}}};
              mem_write_data    <= victim_line;
            end else begin
              mem_read_request  <= 1'b1;
              mem_addr          <= {addr_tag, set_idx, {(LINE_ADDR_LEN+2){1'b0}}};
            end
          end
        end
        SWAP_OUT: begin
          if (mem_request_finish) begin
            mem_write_request <= 1'b0;
            mem_read_request  <= 1'b1;
            mem_addr          <= {addr_tag, set_idx, {(LINE_ADDR_LEN+2){1'b0}}};
          end
        end
        SWAP_IN: begin
          if (mem_request_finish) begin
            mem_read_request <= 1'b0;
            valid[set_idx]   <= 1'b1;
            dirty[set_idx]   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays: hit writes and line fills.
  // NOTE: the storage arrays carry no reset; valid bits gate every use, so
  // resetting them would only add reset fan-out and block RAM mapping.
  always_ff @(posedge clk) begin
    if (state == READY && hit && wr_req) begin
      data_mem[set_idx][word_off] <= wr_data;
    end else if (state == SWAP_IN && mem_request_finish) begin
      tag_mem[set_idx] <= addr_tag;
      for (int k = 0; k < LINE_SIZE; k++)
        data_mem[set_idx][k] <= mem_read_data[32*(LINE_SIZE-k)-1 -: 32];
    end
  end

endmodule

// File: tb/tb_line_cache.sv
// tb_line_cache: scoreboard bench for line_cache. A flat-memory view of the
// address space predicts every read; a behavioural memory responder serves
// line requests with the fixed 19-cycle finish latency.
module tb_line_cache;

  localparam int LINE_SIZE = 8;

  logic                    clk;
  logic                    rst_n;
  logic                    rd_req;
  logic                    wr_req;
  logic [31:0]             addr;
  logic [31:0]             wr_data;
  logic [31:0]             rd_data;
  logic                    miss;
  logic                    mem_read_request;
  logic                    mem_write_request;
  logic [31:0]             mem_addr;
  logic [32*LINE_SIZE-1:0] mem_write_data;
  logic                    mem_request_finish;
  logic [32*LINE_SIZE-1:0] mem_read_data;

  line_cache dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rd_req             (rd_req),
    .wr_req             (wr_req),
    .addr               (addr),
    .wr_data            (wr_data),
    .rd_data            (rd_data),
    .miss               (miss),
    .mem_read_request   (mem_read_request),
    .mem_write_request  (mem_write_request),
    .mem_addr           (mem_addr),
    .mem_write_data     (mem_write_data),
    .mem_request_finish (mem_request_finish),
    .mem_read_data      (mem_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int compared   = 0;
  int mismatched = 0;

  // Backing store (main memory) and CPU-visible view, keyed by word address.
  logic [31:0] backing [int];
  logic [31:0] view    [int];
  logic [31:0] exp_q   [$];

  int          txn_count = 0;
  int          both_cnt  = 0;
  logic [31:0] last_wb_addr;
  logic [32*LINE_SIZE-1:0] last_wb_line;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int wa);
    return backing.exists(wa) ? backing[wa] : 32'(wa) + 32'h0000_00F0;
  endfunction

  function automatic logic [31:0] view_rd(input int wa);
    return view.exists(wa) ? view[wa] : mem_word(wa);
  endfunction

  // Memory responder: a request seen in cycle i finishes in cycle i+19.
  initial begin
    int          cnt;
    bit          busy;
    bit          txn_wr;
    logic [31:0] txn_addr;
    logic [32*LINE_SIZE-1:0] txn_line;
    mem_request_finish = 1'b0;
    mem_read_data      = '0;
    busy = 0;
    cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_request_finish = 1'b0;
      if (!rst_n) begin
        busy = 0;
      end else if (busy) begin
        cnt++;
        if (cnt == 19) begin
          if (txn_wr) begin
            for (int k = 0; k < LINE_SIZE; k++)
              backing[int'(txn_addr >> 2) + k] = txn_line[32*(LINE_SIZE-k)-1 -: 32];
            last_wb_addr = txn_addr;
            last_wb_line = txn_line;
          end else begin
            for (int k = 0; k < LINE_SIZE; k++)
              mem_read_data[32*(LINE_SIZE-k)-1 -: 32] = mem_word(int'(txn_addr >> 2) + k);
          end
          mem_request_finish = 1'b1;
          busy = 0;
        end
      end else if (mem_read_request || mem_write_request) begin
        busy     = 1;
        cnt      = 0;
        txn_wr   = mem_write_request;
        txn_addr = mem_addr;
        txn_line = mem_write_data;
        txn_count++;
        check("mem_addr_aligned", {27'd0, mem_addr[4:0]}, 32'd0);
      end
    end
  end

  // Monitor: pop and compare whenever a read completes.
  always @(negedge clk) begin
    if (mem_read_request && mem_write_request) both_cnt++;
    if (rst_n && rd_req && !wr_req && !miss) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL rd_data: unexpected read completion got 0x%08h", rd_data);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  // One CPU access; entered and left just after a rising edge.
  task automatic do_op(input bit is_wr, input bit is_rd, input logic [31:0] a,
                       input logic [31:0] d, output int mc, output int rq,
                       output int wq, output logic [31:0] rq_addr,
                       output logic [31:0] wq_addr);
    rd_req  = is_rd;
    wr_req  = is_wr;
    addr    = a;
    wr_data = d;
    if (is_wr) view[int'(a >> 2)] = d;
    else       exp_q.push_back(view_rd(int'(a >> 2)));
    mc = 0; rq = 0; wq = 0; rq_addr = 'x; wq_addr = 'x;
    forever begin
      @(negedge clk);
      if (mem_read_request)  begin rq++; rq_addr = mem_addr; end
      if (mem_write_request) begin wq++; wq_addr = mem_addr; end
      if (!miss) break;
      mc++;
      if (mc > 100) begin
        compared++;
        mismatched++;
        $display("FAIL op_timeout: addr 0x%08h still stalled after %0d cycles", a, mc);
        break;
      end
    end
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  initial begin
    int mc, rq, wq, t0;
    logic [31:0] ra, wa;

    rst_n = 1'b0; rd_req = 1'b1; wr_req = 1'b0; addr = 32'h40; wr_data = '0;
    #12;
    check("miss_in_reset", {31'd0, miss}, 32'd1);
    rd_req = 1'b0;
    #1;
    check("reset_miss", {31'd0, miss}, 32'd0);
    check("reset_rreq", {31'd0, mem_read_request}, 32'd0);
    check("reset_wreq", {31'd0, mem_write_request}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_wdata_or", {31'd0, |mem_write_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean miss on 0x40.
    do_op(0, 1, 32'h40, 0, mc, rq, wq, ra, wa);
    check("clean_miss_cycles", mc, 22);
    check("clean_rreq_cycles", rq, 20);
    check("clean_wreq_cycles", wq, 0);
    check("clean_fill_addr", ra, 32'h40);

    // Hits on the resident line issue no memory traffic.
    t0 = txn_count;
    do_op(0, 1, 32'h44, 0, mc, rq, wq, ra, wa);
    check("hit44_stall", mc, 0);
    do_op(0, 1, 32'h5C, 0, mc, rq, wq, ra, wa);
    check("hit5c_stall", mc, 0);
    do_op(1, 0, 32'h48, 32'hDEAD_BEEF, mc, rq, wq, ra, wa);
    check("hit_write_stall", mc, 0);
    do_op(0, 1, 32'h48, 0, mc, rq, wq, ra, wa);
    check("hit48_stall", mc, 0);
    check("hit_no_mem_txn", txn_count - t0, 0);

    // Conflict with a dirty line: write-back then fill.
    do_op(0, 1, 32'h1048, 0, mc, rq, wq, ra, wa);
    check("dirty_miss_cycles", mc, 42);
    check("dirty_wreq_cycles", wq, 20);
    check("dirty_rreq_cycles", rq, 20);
    check("wb_addr", wa, 32'h40);
    check("fill_addr", ra, 32'h1040);
    check("wb_addr_seen", last_wb_addr, 32'h40);
    check("wb_word2", last_wb_line[191:160], 32'hDEAD_BEEF);

    // Clean miss in a different set.
    do_op(0, 1, 32'h80, 0, mc, rq, wq, ra, wa);
    check("clean80_cycles", mc, 22);
    check("clean80_wreq", wq, 0);

    // Reset in the middle of a fill.
    rd_req = 1'b1; wr_req = 1'b0; addr = 32'h2040;
    repeat (10) @(posedge clk);
    #2;
    check("pre_reset_rreq", {31'd0, mem_read_request}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_rreq", {31'd0, mem_read_request}, 32'd0);
    check("abort_wreq", {31'd0, mem_write_request}, 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    rd_req = 1'b0;
    view.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(0, 1, 32'h1048, 0, mc, rq, wq, ra, wa);
    check("post_reset_miss", mc, 22);

    // Randomized mix over conflicting tags.
    for (int i = 0; i < 200; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 5) | ($urandom_range(0, 7) << 2);
      case (kind)
        0, 1:    do_op(0, 1, a, 0, mc, rq, wq, ra, wa);
        2:       do_op(1, 0, a, $urandom, mc, rq, wq, ra, wa);
        default: do_op(1, 1, a, $urandom, mc, rq, wq, ra, wa);
      endcase
    end

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("never_both_requests", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
